// File: rtl/fetch_prefetch_queue.sv
// In-order prefetch queue between instruction memory and decode.
// Slots are allocated on request acceptance, filled by in-order responses, and popped by decode.
module fetch_prefetch_queue #(
  parameter int unsigned             ADDR_W   = 32,
  parameter int unsigned             INSTR_W  = 32,
  parameter int unsigned             DEPTH    = 4,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_redirect,
  input  logic [ADDR_W-1:0]          i_redirect_addr,
  input  logic                       i_stall,
  output logic                       o_req_valid,
  output logic [ADDR_W-1:0]          o_req_addr,
  input  logic                       i_req_ready,
  input  logic                       i_rsp_valid,
  input  logic [INSTR_W-1:0]         i_rsp_data,
  output logic                       o_valid,
  output logic [INSTR_W-1:0]         o_instr,
  output logic [ADDR_W-1:0]          o_pc,
  output logic [ADDR_W-1:0]          o_pc4,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d, unfilled_q, unfilled_d, drop_q, drop_d;
  logic              err_q, err_d;

  logic              req_ok, accept, pop, head_filled, fill_en;
  logic [CNT_W:0]    credit_used, outstanding;

  assign credit_used = {1'b0, count_q} + {1'b0, drop_q};
  assign outstanding = {1'b0, unfilled_q} + {1'b0, drop_q};
  // Filled slots are contiguous from the head, so the head is filled iff any slot is.
  assign head_filled = (count_q != unfilled_q);
  assign req_ok      = !i_rst && !i_redirect && (credit_used < DEPTH_C);
  assign accept      = req_ok && i_req_ready;
  assign pop         = head_filled && !i_stall && !i_redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    fill_d     = fill_q;
    tail_d     = tail_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    drop_d     = drop_q;
    err_d      = err_q;
    fill_en    = 1'b0;
    if (i_redirect) begin
      fetch_pc_d = i_redirect_addr;
      head_d     = tail_q;
      fill_d     = tail_q;
      count_d    = '0;
      unfilled_d = '0;
      // Everything still in flight becomes a drop; a response this cycle retires one of them.
      if (i_rsp_valid) begin
        if (outstanding != '0) drop_d = CNT_W'(outstanding - (CNT_W+1)'(1));
        else                   err_d  = 1'b1;
      end else begin
        drop_d = CNT_W'(outstanding);
      end
    end else begin
      if (i_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else if (unfilled_q != '0) begin
          fill_en = 1'b1;
          fill_d  = fill_q + PTR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      if (pop) head_d = head_q + PTR_W'(1);
      if (accept) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (accept && !pop)      count_d = count_q + CNT_W'(1);
      else if (!accept && pop) count_d = count_q - CNT_W'(1);
      if (accept && !fill_en)      unfilled_d = unfilled_q + CNT_W'(1);
      else if (!accept && fill_en) unfilled_d = unfilled_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      fill_q     <= fill_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept)  pc_q[tail_q]    <= fetch_pc_q;
    if (fill_en) instr_q[fill_q] <= i_rsp_data;
  end

  assign o_req_valid = req_ok;
  assign o_req_addr  = i_rst ? '0 : fetch_pc_q;
  assign o_valid     = !i_rst && head_filled;
  assign o_instr     = o_valid ? instr_q[head_q] : '0;
  assign o_pc        = o_valid ? pc_q[head_q] : '0;
  assign o_pc4       = o_valid ? pc_q[head_q] + ADDR_W'(4) : '0;
  assign o_count     = i_rst ? '0 : count_q;
  assign o_err       = !i_rst && err_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order variable-latency memory model plus a slot-queue reference model.
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, redirect, stall, req_ready, rsp_valid;
  logic [31:0] redirect_addr, rsp_data;
  logic        req_valid, valid, err;
  logic [31:0] req_addr, instr, pc, pc4;
  logic [2:0]  count;

  fetch_prefetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_redirect(redirect), .i_redirect_addr(redirect_addr),
    .i_stall(stall), .o_req_valid(req_valid), .o_req_addr(req_addr), .i_req_ready(req_ready),
    .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data), .o_valid(valid), .o_instr(instr),
    .o_pc(pc), .o_pc4(pc4), .o_count(count), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } slot_t;
  typedef struct { logic [31:0] addr; int due; } memreq_t;

  slot_t       mq[$];
  memreq_t     mem[$];
  logic [31:0] m_fetch;
  int          m_drop;
  bit          m_err;
  int          cyc = 0;
  int          lat = 1;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then advance models.
  task automatic step(input bit r, input bit rd, input logic [31:0] ra,
                      input bit st, input bit rdy, input bit spur);
    bit          mem_rsp, e_req, e_valid, pop, alloc;
    logic [31:0] d;
    int          unf, outst, idx;
    @(negedge clk);
    cyc++;
    mem_rsp = (mem.size() > 0) && (mem[0].due <= cyc);
    d = mem_rsp ? mem_data(mem[0].addr) : 32'h0;
    rst = r; redirect = rd; redirect_addr = ra; stall = st; req_ready = rdy;
    rsp_valid = mem_rsp || spur;
    rsp_data  = (spur && !mem_rsp) ? $urandom : d;
    #1;
    e_req   = !r && !rd && (mq.size() + m_drop < DEPTH);
    e_valid = !r && mq.size() > 0 && mq[0].filled;
    chk("req_valid", {63'd0, req_valid}, {63'd0, e_req});
    chk("req_addr",  {32'd0, req_addr},  {32'd0, r ? 32'h0 : m_fetch});
    chk("valid",     {63'd0, valid},     {63'd0, e_valid});
    chk("pc",        {32'd0, pc},        {32'd0, e_valid ? mq[0].pc : 32'h0});
    chk("pc4",       {32'd0, pc4},       {32'd0, e_valid ? mq[0].pc + 32'd4 : 32'h0});
    chk("instr",     {32'd0, instr},     {32'd0, e_valid ? mq[0].instr : 32'h0});
    chk("count",     {61'd0, count},     r ? 64'd0 : 64'(mq.size()));
    chk("err",       {63'd0, err},       {63'd0, !r && m_err});
    if (mem_rsp) void'(mem.pop_front());
    if (req_valid && rdy) mem.push_back('{addr: req_addr, due: cyc + lat});
    if (r) mem.delete();
    if (r) begin
      m_fetch = 32'h0; mq.delete(); m_drop = 0; m_err = 0;
    end else if (rd) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      outst = unf + m_drop;
      if (rsp_valid) begin
        if (outst > 0) outst--; else m_err = 1;
      end
      m_drop = outst; mq.delete(); m_fetch = ra;
    end else begin
      pop   = mq.size() > 0 && mq[0].filled && !st;
      alloc = e_req && rdy;
      if (rsp_valid) begin
        if (m_drop > 0) m_drop--;
        else begin
          idx = -1;
          foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
          if (idx >= 0) begin mq[idx].filled = 1; mq[idx].instr = rsp_data; end
          else m_err = 1;
        end
      end
      if (pop) void'(mq.pop_front());
      if (alloc) begin
        mq.push_back('{pc: m_fetch, instr: 32'h0, filled: 0});
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
  endtask

  initial begin
    bit got;
    rst = 1; redirect = 0; redirect_addr = 0; stall = 0; req_ready = 1;
    rsp_valid = 0; rsp_data = 0;
    m_fetch = 0; m_drop = 0; m_err = 0;

    // Streaming at L=1: first valid two cycles after the first request.
    lat = 1; do_reset();
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 1, 0);
      if (i == 2) begin
        chk("t1_first_valid", {63'd0, valid}, 64'd1);
        chk("t1_first_pc",    {32'd0, pc},    64'h0);
        chk("t1_first_pc4",   {32'd0, pc4},   64'h4);
      end
    end

    // Stall from the start fills the queue, then drains.
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 0);
    chk("t2_full_count", {61'd0, count}, 64'd4);
    chk("t2_full_noreq", {63'd0, req_valid}, 64'd0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 0);

    // Redirect with two requests in flight at L=3.
    lat = 3; do_reset();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 32'h100, 0, 1, 0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, 0, 0, 1, 0);
      if (valid) begin
        got = 1;
        chk("t3_pc",    {32'd0, pc},    64'h100);
        chk("t3_instr", {32'd0, instr}, {32'd0, mem_data(32'h100)});
        chk("t3_err",   {63'd0, err},   64'd0);
      end
    end
    chk("t3_valid_seen", {63'd0, got}, 64'd1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0);

    // Address wrap at the top of the space.
    lat = 1; do_reset();
    step(0, 1, 32'hFFFF_FFF8, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 1, 0);
      if (k == 4) begin
        chk("t4_wrap_pc",  {32'd0, pc},  64'hFFFF_FFFC);
        chk("t4_wrap_pc4", {32'd0, pc4}, 64'h0);
      end
    end

    // Memory not ready: request held, nothing allocated.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    chk("t5_addr_held", {32'd0, req_addr}, 64'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0);

    // Spurious response sets a sticky error cleared only by reset.
    do_reset();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    chk("t6_err_sticky", {63'd0, err}, 64'd1);
    chk("t6_count",      {61'd0, count}, 64'd0);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("t6_err_cleared", {63'd0, err}, 64'd0);

    // Randomized traffic with redirects, stalls, backpressure, resets and spurious responses.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      step(($urandom % 100) == 0, ($urandom % 16) == 0, $urandom & 32'hFFFF_FFFC,
           ($urandom % 4) == 0, ($urandom % 4) != 0,
           (mem.size() == 0) && (($urandom % 60) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
